// File: rtl/img2col_pu_gen.sv
// img2col processing unit: assembles one KxK convolution window per output pixel
// from a multi-lane input stream. Later windows in a row reuse the overlapping
// K-STRIDE columns of the previous window, which are also exported to the
// neighbouring PU.
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   start              begin a new row with a full KxK fill (honoured only when idle)
//   row_done           sampled on window accept; 1 = last window of the row
//   in_valid/in_ready  input beat handshake; lane i of in_data goes to fill_cnt+i
//   win_valid/win_ready window handshake; win_data is column-major (col*K + row)
//   nb_valid/nb_data   one-cycle pulse with the reused columns of the old window
//   win_cnt            windows accepted in the current row
//   busy               unit is not idle
module img2col_pu_gen #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned K       = 5,
    parameter int unsigned STRIDE  = 1,
    parameter int unsigned N_LANES = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                                         clk,
    input  logic                                         nrst,
    input  logic                                         start,
    input  logic                                         row_done,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [N_LANES*DATA_W-1:0]                    in_data,
    output logic                                         win_valid,
    input  logic                                         win_ready,
    output logic [K*K*DATA_W-1:0]                        win_data,
    output logic                                         nb_valid,
    output logic [((K*(K-STRIDE) > 0) ? K*(K-STRIDE) : 1)*DATA_W-1:0] nb_data,
    output logic [CNT_W-1:0]                             win_cnt,
    output logic                                         busy
);

    localparam int unsigned KK   = K * K;
    localparam int unsigned NEW  = K * STRIDE;
    localparam int unsigned RES  = KK - NEW;
    localparam int unsigned NB_N = (RES > 0) ? RES : 1;
    localparam int unsigned FW   = $clog2(KK + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StWin  = 2'd2;

    if (STRIDE < 1 || STRIDE > K || N_LANES < 1 || N_LANES > K) begin : g_param_err
        $error("img2col_pu_gen: STRIDE and N_LANES must lie in 1..K");
    end

    logic [1:0]        state_q, state_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              nb_valid_q, nb_valid_d;
    logic [DATA_W-1:0] win_q [KK];
    logic [DATA_W-1:0] win_d [KK];
    logic [DATA_W-1:0] nb_q  [NB_N];
    logic [DATA_W-1:0] nb_d  [NB_N];

    always_comb begin
        int off;
        state_d    = state_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        nb_valid_d = 1'b0;
        win_d      = win_q;
        nb_d       = nb_q;
        off        = 0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    fill_d  = '0;
                    cnt_d   = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (in_valid) begin
                    // Only positions below KK exist, so surplus lanes fall away here.
                    for (int p = 0; p < int'(KK); p++) begin
                        off = p - int'(fill_q);
                        if (off >= 0 && off < int'(N_LANES)) begin
                            win_d[p] = in_data[off*DATA_W +: DATA_W];
                        end
                    end
                    if (int'(fill_q) + int'(N_LANES) >= int'(KK)) begin
                        fill_d  = FW'(KK);
                        state_d = StWin;
                    end else begin
                        fill_d = fill_q + FW'(N_LANES);
                    end
                end
            end
            StWin: begin
                if (win_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (row_done) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StFill;
                        if (RES > 0) begin
                            // Slide the window left by STRIDE columns; the kept
                            // columns are exactly what the neighbour needs.
                            for (int j = 0; j < int'(RES); j++) begin
                                win_d[j] = win_q[j + int'(NEW)];
                                nb_d[j]  = win_q[j + int'(NEW)];
                            end
                            nb_valid_d = 1'b1;
                            fill_d     = FW'(RES);
                        end else begin
                            fill_d = '0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            fill_q     <= '0;
            cnt_q      <= '0;
            nb_valid_q <= 1'b0;
            for (int i = 0; i < int'(KK); i++) win_q[i] <= '0;
            for (int i = 0; i < int'(NB_N); i++) nb_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            nb_valid_q <= nb_valid_d;
            for (int i = 0; i < int'(KK); i++) win_q[i] <= win_d[i];
            for (int i = 0; i < int'(NB_N); i++) nb_q[i] <= nb_d[i];
        end
    end

    always_comb begin
        win_data = '0;
        nb_data  = '0;
        for (int i = 0; i < int'(KK); i++) win_data[i*DATA_W +: DATA_W] = win_q[i];
        for (int i = 0; i < int'(NB_N); i++) nb_data[i*DATA_W +: DATA_W] = nb_q[i];
    end

    assign in_ready  = (state_q == StFill);
    assign win_valid = (state_q == StWin);
    assign busy      = (state_q != StIdle);
    assign nb_valid  = nb_valid_q;
    assign win_cnt   = cnt_q;

endmodule

// File: doc/img2col_pu_gen.md
Name: img2col_pu_gen

Overview:
- Parametrised img2col processing unit that assembles one KxK convolution window per output pixel from a streamed multi-lane input.
- Keeps the overlapping K-STRIDE columns of the previous window, so each later window in a row needs only K*STRIDE new values.
- Exports the reused columns to the neighbouring PU.
- Sits between the AXI input feeder and the MAC array; adds stride, lane count, valid/ready handshakes and row sequencing.

Parameters:
- DATA_W, 16, element width in bits.
- K, 5, kernel side; window holds K*K elements.
- STRIDE, 1, horizontal stride, legal range 1..K; RES = K*(K-STRIDE) elements are reused.
- N_LANES, 2, input elements per beat, legal range 1..K.
- CNT_W, 16, width of the window counter.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  begin a new row; full KxK fill (honoured only in IDLE)
- row_done  in  1  sampled at window acceptance; 1 = last window of the row
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts a beat
- in_data  in  N_LANES x DATA_W  lane i carries the element at fill index fill_cnt+i
- win_valid  out  1  window complete
- win_ready  in  1  consumer accepts window
- win_data  out  K*K x DATA_W  window, column-major: index = col*K + row
- nb_valid  out  1  one-cycle pulse, reused columns exported
- nb_data  out  RES x DATA_W  reused elements (previous window columns STRIDE..K-1)
- win_cnt  out  CNT_W  windows accepted in the current row
- busy  out  1  state != IDLE

Behaviour:
- Reset: asynchronous on nrst=0.
  - State goes to IDLE.
  - All window and nb registers are cleared to 0; fill_cnt=0, win_cnt=0.
  - in_ready, win_valid, nb_valid and busy are 0.
  - Reset mid-operation discards any partial window; no output pulse is produced.
- FSM has three states: IDLE, FILL, WIN.
- IDLE:
  - On start=1: fill_cnt=0, win_cnt=0, go to FILL.
  - in_ready=0.
- FILL:
  - in_ready=1.
  - Beat accept: in_valid & in_ready.
  - On accept, lane i with fill_cnt+i < K*K writes win reg[fill_cnt+i]. Lanes at or beyond K*K are ignored.
  - fill_cnt advances by min(N_LANES, K*K-fill_cnt).
  - When the accepted beat makes fill_cnt reach K*K, go to WIN next cycle. Latency is 1 cycle from the final beat to win_valid=1.
- WIN:
  - win_valid=1, in_ready=0.
  - win_data is held stable until accepted.
  - Accept is win_valid & win_ready; on accept, win_cnt increments and wraps at 2^CNT_W.
  - If row_done=1 at accept: go to IDLE. Window registers retain their values.
  - If row_done=0 and RES>0 at accept:
    - In the same cycle, reg[j] <= reg[j+K*STRIDE] for j < RES.
    - nb_data <= old reg[K*STRIDE .. K*K-1].
    - nb_valid pulses high the next cycle for exactly one cycle.
    - fill_cnt <= RES; go to FILL.
  - If row_done=0 and RES=0 (STRIDE=K): no shift, no nb pulse, fill_cnt <= 0, go to FILL.
- win_data is always driven from the window registers; its contents are meaningful only while win_valid=1.
- A start asserted outside IDLE is ignored; it is not queued.
- in_valid outside FILL has no effect.
- win_ready outside WIN has no effect.
- No combinational path from in_valid or win_ready to in_ready or win_valid; all handshake outputs are registered-state decodes.
- Elaboration error if STRIDE<1, STRIDE>K, N_LANES<1 or N_LANES>K.

Test Plan:
- Full fill, K=5/S=1/N=2: pulse start, then 13 beats carrying values 1..26 (lane1 of the last beat = 26). Required: win_valid rises the cycle after beat 13; win_data[i]=i+1 for i=0..24; value 26 is dropped; in_ready=0 in WIN.
- Partial fill: accept with row_done=0, then 3 beats carrying 101..106. Required:
  - nb_valid pulses once with nb_data = 6..25.
  - New window: win_data[0..19]=6..25, [20..24]=101..105; 106 is dropped.
  - win_cnt goes 1 then 2.
- Backpressure: hold win_ready=0 for 4 cycles while in_valid=1. Required: win_data is unchanged, in_ready=0, fill_cnt is not advanced; accept occurs on the cycle win_ready=1.
- Row end: accept with row_done=1. Required: IDLE next cycle, busy=0, no nb pulse; a following start restarts a full 25-element fill with win_cnt=0.
- Reset mid-fill: drop nrst after 7 beats. Required: all outputs 0 immediately; after release the unit stays idle until start; a stale partial window never appears.
- Parameter variant K=3/S=3/N=3: each window needs 3 beats; no nb_valid pulse ever; the second window contains only new data.
